// File: rtl/router_sync_n.sv
// Router-to-FIFO synchroniser: address latch/decode, full-flag mux, valid-out and per-channel soft-reset watchdog.
// Optional build macro ROUTER_SYNC_SRST_CNT_EN adds per-channel saturating s_rst pulse counters (srst_cnt).
module router_sync_n #(
  parameter int N_CH    = 3,
  parameter int AW      = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              det_addr,
  input  logic [AW-1:0]     d_in,
  input  logic              w_enb_reg,
  input  logic [N_CH-1:0]   full,
  input  logic [N_CH-1:0]   empty,
  input  logic [N_CH-1:0]   r_enb,
  output logic [N_CH-1:0]   w_enb,
  output logic              f_full,
  output logic              addr_err,
  output logic [N_CH-1:0]   vld_out,
  output logic [N_CH-1:0]   s_rst
`ifdef ROUTER_SYNC_SRST_CNT_EN
  ,
  output logic [8*N_CH-1:0] srst_cnt
`endif
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [AW:0]   NCH_L  = (AW+1)'(N_CH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [AW-1:0]   r_addr;
  logic            r_addr_err;
  logic [TW-1:0]   r_timer [N_CH];
  logic [N_CH-1:0] r_s_rst;
  logic [N_CH-1:0] w_w_enb;
  logic            w_f_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else if (det_addr) begin
      r_addr     <= d_in;
      r_addr_err <= ({1'b0, d_in} >= NCH_L);
    end
  end

  // An out-of-range address forces f_full high so the FSM never writes a misrouted packet.
  always_comb begin
    w_w_enb  = '0;
    w_f_full = r_addr_err;
    for (int i = 0; i < N_CH; i++) begin
      if (r_addr == AW'(i)) begin
        w_w_enb[i] = w_enb_reg & ~r_addr_err;
        if (!r_addr_err) w_f_full = full[i];
      end
    end
  end

  assign w_enb    = w_w_enb;
  assign f_full   = w_f_full;
  assign addr_err = r_addr_err;
  assign vld_out  = ~empty;
  assign s_rst    = r_s_rst;

  // Each channel counts unread-valid cycles on its own; expiry pulses s_rst once and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_timer[i] <= '0;
      r_s_rst <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (vld_out[i] && !r_enb[i]) begin
          if (r_timer[i] == T_LAST) begin
            r_s_rst[i] <= 1'b1;
            r_timer[i] <= '0;
          end else begin
            r_s_rst[i] <= 1'b0;
            r_timer[i] <= r_timer[i] + TW'(1);
          end
        end else begin
          r_s_rst[i] <= 1'b0;
          r_timer[i] <= '0;
        end
      end
    end
  end

`ifdef ROUTER_SYNC_SRST_CNT_EN
  logic [7:0] r_cnt [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_s_rst[i] && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    srst_cnt = '0;
    for (int i = 0; i < N_CH; i++) srst_cnt[8*i +: 8] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (N_CH=3, AW=2, TIMEOUT=30); covers srst_cnt when ROUTER_SYNC_SRST_CNT_EN is defined.
module tb_router_sync_n;

  logic       clk;
  logic       rst;
  logic       det_addr;
  logic [1:0] d_in;
  logic       w_enb_reg;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] r_enb;
  logic [2:0] w_enb;
  logic       f_full;
  logic       addr_err;
  logic [2:0] vld_out;
  logic [2:0] s_rst;
`ifdef ROUTER_SYNC_SRST_CNT_EN
  logic [23:0] srst_cnt;
`endif

  int n_chk;
  int n_bad;

  router_sync_n #(.N_CH(3), .AW(2), .TIMEOUT(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .det_addr  (det_addr),
    .d_in      (d_in),
    .w_enb_reg (w_enb_reg),
    .full      (full),
    .empty     (empty),
    .r_enb     (r_enb),
    .w_enb     (w_enb),
    .f_full    (f_full),
    .addr_err  (addr_err),
    .vld_out   (vld_out),
    .s_rst     (s_rst)
`ifdef ROUTER_SYNC_SRST_CNT_EN
    ,
    .srst_cnt  (srst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    empty = 3'b111;
    r_enb = 3'b000;
    step();
    step();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1; det_addr = 1'b0; d_in = 2'd0; w_enb_reg = 1'b0;
    full = 3'b000; empty = 3'b111; r_enb = 3'b000;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_s_rst", 32'(s_rst), 32'd0);
    check_eq("rst_addr_err", 32'(addr_err), 32'd0);
    check_eq("rst_w_enb_idle", 32'(w_enb), 32'd0);
    check_eq("rst_vld_out", 32'(vld_out), 32'd0);
    w_enb_reg = 1'b1; full = 3'b001; #1;
    check_eq("rst_w_enb_ch0", 32'(w_enb), 32'b001);
    check_eq("rst_f_full_hi", 32'(f_full), 32'd1);
    full = 3'b110; #1;
    check_eq("rst_f_full_lo", 32'(f_full), 32'd0);

    // Latch address 2; w_enb uses the old address during the det_addr cycle.
    step();
    d_in = 2'd2; det_addr = 1'b1; #1;
    check_eq("dec_same_cycle", 32'(w_enb), 32'b001);
    step();
    det_addr = 1'b0; d_in = 2'd0; #1;
    check_eq("dec_w_enb2", 32'(w_enb), 32'b100);
    check_eq("dec_addr_err", 32'(addr_err), 32'd0);
    full = 3'b100; #1;
    check_eq("dec_f_full_hi", 32'(f_full), 32'd1);
    full = 3'b011; #1;
    check_eq("dec_f_full_lo", 32'(f_full), 32'd0);
    w_enb_reg = 1'b0; #1;
    check_eq("dec_w_enb_off", 32'(w_enb), 32'd0);

    // Out-of-range address 3.
    w_enb_reg = 1'b1; d_in = 2'd3; det_addr = 1'b1;
    step();
    det_addr = 1'b0; full = 3'b000; #1;
    check_eq("bad_addr_err", 32'(addr_err), 32'd1);
    check_eq("bad_w_enb", 32'(w_enb), 32'd0);
    check_eq("bad_f_full_0", 32'(f_full), 32'd1);
    full = 3'b111; #1;
    check_eq("bad_f_full_1", 32'(f_full), 32'd1);
    d_in = 2'd1; det_addr = 1'b1;
    step();
    det_addr = 1'b0; full = 3'b000; #1;
    check_eq("rec_addr_err", 32'(addr_err), 32'd0);
    check_eq("rec_w_enb1", 32'(w_enb), 32'b010);
    check_eq("rec_f_full", 32'(f_full), 32'd0);
    w_enb_reg = 1'b0;
    empty = 3'b010; #1;
    check_eq("vld_out", 32'(vld_out), 32'b101);
    idle();

    // Channel 1 stalled for 65 cycles: pulses on cycles 30 and 60 only.
    empty = 3'b101; r_enb = 3'b000;
    for (int c = 0; c < 65; c++) begin
      #1;
      check_eq($sformatf("tmo_c%0d", c), 32'(s_rst), (c == 30 || c == 60) ? 32'b010 : 32'd0);
      step();
    end
    idle();

    // Channels 0 and 2 stalled; channel 0 read once at cycle 10.
    empty = 3'b010;
    for (int c = 0; c < 46; c++) begin
      r_enb = (c == 10) ? 3'b001 : 3'b000;
      #1;
      check_eq($sformatf("ind_c%0d", c), 32'(s_rst),
               32'({(c == 30), 1'b0, (c == 41)}));
      step();
    end
    idle();

    // Channel 0 stalled; reset held over cycles 20-21.
    empty = 3'b110;
    for (int c = 0; c < 56; c++) begin
      if (c == 20) rst = 1'b1;
      if (c == 22) rst = 1'b0;
      #1;
      check_eq($sformatf("rmc_c%0d", c), 32'(s_rst), (c == 52) ? 32'b001 : 32'd0);
      step();
    end

`ifdef ROUTER_SYNC_SRST_CNT_EN
    check_eq("cnt_after_rst", 32'(srst_cnt), 32'h000001);
    idle();
    empty = 3'b110;
    for (int c = 0; c < 9010; c++) begin
      if (c == 31) begin
        #1;
        check_eq("cnt_first", 32'(srst_cnt[7:0]), 32'd2);
      end
      step();
    end
    #1;
    check_eq("cnt_sat", 32'(srst_cnt[7:0]), 32'd255);
    check_eq("cnt_others", 32'(srst_cnt[23:8]), 32'd0);
    for (int c = 0; c < 200; c++) step();
    #1;
    check_eq("cnt_hold", 32'(srst_cnt[7:0]), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
